imem_port_arbiter: RTL

Two-requester arbiter that shares the single synchronous-read instruction memory port between instruction fetch (requester IF) and a data/debug read path (requester DM). It sits between the fetch stage and the instruction memory: it drives the memory read address/enable, grants one requester per cycle, and routes the returned word to the owner one cycle later. The block enforces a fetch-priority policy with a starvation guard and a DM lock for multi-word reads.

---
 rtl/imem_port_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Shares the single synchronous-read instruction memory port between fetch (IF) and DM reads.
// Define IMEM_ARB_RR_EN to resolve plain IF/DM conflicts round-robin instead of IF-first.
module imem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic [31:0] i_dm_addr,
  input  logic        i_dm_lock,
  output logic        o_dm_gnt,
  output logic        o_dm_rvalid,
  output logic [31:0] o_dm_rdata,
  output logic        o_mem_ren,
  output logic [31:0] o_mem_raddr,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StOwnIf, StOwnDm} owner_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_WAIT);

  owner_e           owner_q;
  logic             lock_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             if_rvalid_q;
  logic             dm_rvalid_q;

  logic lock_hit;
  logic starve;
  logic conflict_dm;
  logic dm_win;
  logic if_gnt;
  logic dm_gnt;

`ifdef IMEM_ARB_RR_EN
  logic last_if_q;

  // Conflicts go to whichever requester was not granted most recently; IF first after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_if_q <= 1'b0;
    end else if (if_gnt) begin
      last_if_q <= 1'b1;
    end else if (dm_gnt) begin
      last_if_q <= 1'b0;
    end
  end

  assign conflict_dm = last_if_q;
`else
  assign conflict_dm = 1'b0;
`endif

  always_comb begin
    lock_hit = (owner_q == StOwnDm) && lock_q && i_dm_req;
    starve   = (wait_cnt_q == MaxCnt) && i_dm_req;
    dm_win   = lock_hit || starve || (i_dm_req && (!i_if_req || conflict_dm));
    // Grants are suppressed for as long as reset is held.
    dm_gnt   = !i_rst && dm_win;
    if_gnt   = !i_rst && i_if_req && !dm_win;
  end

  assign o_if_gnt    = if_gnt;
  assign o_dm_gnt    = dm_gnt;
  assign o_mem_ren   = if_gnt | dm_gnt;
  assign o_mem_raddr = if_gnt ? i_if_addr : (dm_gnt ? i_dm_addr : 32'h0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q     <= StIdle;
      lock_q      <= 1'b0;
      wait_cnt_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      owner_q     <= dm_gnt ? StOwnDm : (if_gnt ? StOwnIf : StIdle);
      lock_q      <= dm_gnt & i_dm_lock;
      if_rvalid_q <= if_gnt;
      dm_rvalid_q <= dm_gnt;
      if (dm_gnt || !i_dm_req) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != MaxCnt) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  // Memory data arrives the cycle after the grant; only the owner sees it.
  assign o_if_rvalid = if_rvalid_q;
  assign o_dm_rvalid = dm_rvalid_q;
  assign o_if_rdata  = if_rvalid_q ? i_mem_rdata : 32'h0;
  assign o_dm_rdata  = dm_rvalid_q ? i_mem_rdata : 32'h0;

endmodule
